// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Supervises up to eight PLLs that share one reference clock. For each PLL it
// pulses the PLL reset, qualifies lock over a stable window, retries on lock
// timeout, and releases that PLL's domain reset in a staggered order. It
// re-runs the sequence on loss of lock and counts the loss events.
//
// Ports
//   refclk        in   reference clock, the only clock in this block
//   rst_n         in   async active-low reset (deassertion synchronised here)
//   pll_locked    in   raw PLL lock flags, asynchronous to refclk
//   clr_cnt       in   pulse: clear all lock-loss counters
//   clr_fault     in   per-channel pulse: leave FAULT
//   pll_rst       out  active-high reset to each PLL
//   domain_rst_n  out  active-low reset for each PLL output clock domain
//   all_locked    out  every channel in RUN (registered)
//   fault         out  channel is in FAULT
//   lock_loss_cnt out  saturating loss counters, channel i at [i*CNT_W +: CNT_W]
//
// Channel FSM
//   state     | meaning
//   RESET     | PLL held in reset for RST_PULSE_CYC cycles
//   WAIT_LOCK | PLL released, qualifying lock, timeout running
//   STAGGER   | lock qualified, waiting i*RST_STAGGER_CYC+1 cycles
//   RUN       | domain released, watching for loss of lock
//   FAULT     | retries exhausted, PLL held in reset until clr_fault
module pll_lock_supervisor #(
    parameter int NUM_PLL          = 2,
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int MAX_RETRY        = 3,
    parameter int RST_STAGGER_CYC  = 8,
    parameter int CNT_W            = 8
) (
    input  logic                     refclk,
    input  logic                     rst_n,
    input  logic [NUM_PLL-1:0]       pll_locked,
    input  logic                     clr_cnt,
    input  logic [NUM_PLL-1:0]       clr_fault,
    output logic [NUM_PLL-1:0]       pll_rst,
    output logic [NUM_PLL-1:0]       domain_rst_n,
    output logic                     all_locked,
    output logic [NUM_PLL-1:0]       fault,
    output logic [NUM_PLL*CNT_W-1:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        ST_RESET, ST_WAIT_LOCK, ST_STAGGER, ST_RUN, ST_FAULT
    } state_t;

    localparam int STG_MAX = (NUM_PLL - 1) * RST_STAGGER_CYC;
    localparam int PH_MAX  = (STG_MAX > RST_PULSE_CYC) ? STG_MAX : RST_PULSE_CYC;
    localparam int PW      = $clog2(PH_MAX + 1);
    localparam int SW      = $clog2(LOCK_STABLE_CYC + 1);
    localparam int TW      = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int RW      = 4;

    localparam logic [PW-1:0]    PULSE_LAST  = PW'(RST_PULSE_CYC - 1);
    localparam logic [SW-1:0]    STABLE_LAST = SW'(LOCK_STABLE_CYC - 1);
    localparam logic [TW-1:0]    TO_LAST     = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [RW-1:0]    RETRY_MAX   = RW'(MAX_RETRY);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;

    // Reset asserts asynchronously; release is delayed two refclk edges so
    // every channel leaves reset on the same edge.
    logic [1:0] rst_sync;
    logic       rst_rel;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_rel = rst_sync[1];

    logic [NUM_PLL-1:0] lk_meta, locked_s;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta  <= '0;
            locked_s <= '0;
        end else begin
            lk_meta  <= pll_locked;
            locked_s <= lk_meta;
        end
    end

    logic [NUM_PLL-1:0] in_run;

    for (genvar i = 0; i < NUM_PLL; i++) begin : g_ch
        localparam logic [PW-1:0] STG_LOAD = PW'(i * RST_STAGGER_CYC);

        state_t           state, state_nx;
        logic [PW-1:0]    ph_tmr, ph_tmr_nx;
        logic [SW-1:0]    stable_cnt, stable_cnt_nx;
        logic [TW-1:0]    to_cnt, to_cnt_nx;
        logic [RW-1:0]    retry, retry_nx;
        logic [CNT_W-1:0] loss_cnt, loss_cnt_nx;
        logic             loss_ev;
        logic             pll_rst_q, dom_rst_n_q, fault_q;

        always_ff @(posedge refclk or negedge rst_n) begin
            if (!rst_n) begin
                state       <= ST_RESET;
                ph_tmr      <= '0;
                stable_cnt  <= '0;
                to_cnt      <= '0;
                retry       <= '0;
                loss_cnt    <= '0;
                pll_rst_q   <= 1'b1;
                dom_rst_n_q <= 1'b0;
                fault_q     <= 1'b0;
            end else begin
                state       <= state_nx;
                ph_tmr      <= ph_tmr_nx;
                stable_cnt  <= stable_cnt_nx;
                to_cnt      <= to_cnt_nx;
                retry       <= retry_nx;
                loss_cnt    <= loss_cnt_nx;
                // Outputs decode the next state so they change on the same
                // edge as the state register.
                pll_rst_q   <= (state_nx == ST_RESET) || (state_nx == ST_FAULT);
                dom_rst_n_q <= (state_nx == ST_RUN);
                fault_q     <= (state_nx == ST_FAULT);
            end
        end

        always_comb begin
            state_nx      = state;
            ph_tmr_nx     = ph_tmr;
            stable_cnt_nx = stable_cnt;
            to_cnt_nx     = to_cnt;
            retry_nx      = retry;
            loss_ev       = 1'b0;

            if (!rst_rel) begin
                // Held until the synchronised release; preload the pulse
                // timer so the first pulse starts on the release edge.
                state_nx      = ST_RESET;
                ph_tmr_nx     = PULSE_LAST;
                stable_cnt_nx = '0;
                to_cnt_nx     = '0;
                retry_nx      = '0;
            end else begin
                case (state)
                    ST_RESET: begin
                        if (ph_tmr == '0) begin
                            state_nx      = ST_WAIT_LOCK;
                            stable_cnt_nx = '0;
                            to_cnt_nx     = '0;
                        end else begin
                            ph_tmr_nx = ph_tmr - 1'b1;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        to_cnt_nx     = to_cnt + 1'b1;
                        stable_cnt_nx = locked_s[i] ? stable_cnt + 1'b1 : '0;
                        // Qualification is tested first so it wins a tie
                        // with the timeout.
                        if (locked_s[i] && (stable_cnt == STABLE_LAST)) begin
                            state_nx  = ST_STAGGER;
                            ph_tmr_nx = STG_LOAD;
                        end else if (to_cnt == TO_LAST) begin
                            retry_nx = retry + 1'b1;
                            if (retry_nx == RETRY_MAX) begin
                                state_nx = ST_FAULT;
                            end else begin
                                state_nx  = ST_RESET;
                                ph_tmr_nx = PULSE_LAST;
                            end
                        end
                    end
                    ST_STAGGER: begin
                        if (!locked_s[i]) begin
                            state_nx  = ST_RESET;
                            ph_tmr_nx = PULSE_LAST;
                        end else if (ph_tmr == '0) begin
                            state_nx = ST_RUN;
                        end else begin
                            ph_tmr_nx = ph_tmr - 1'b1;
                        end
                    end
                    ST_RUN: begin
                        retry_nx = '0;
                        if (!locked_s[i]) begin
                            loss_ev   = 1'b1;
                            state_nx  = ST_RESET;
                            ph_tmr_nx = PULSE_LAST;
                        end
                    end
                    ST_FAULT: begin
                        if (clr_fault[i]) begin
                            state_nx  = ST_RESET;
                            ph_tmr_nx = PULSE_LAST;
                            retry_nx  = '0;
                        end
                    end
                    default: begin
                        state_nx  = ST_RESET;
                        ph_tmr_nx = PULSE_LAST;
                    end
                endcase
            end

            // A loss coinciding with a clear is kept as the first new event.
            if (!rst_rel)          loss_cnt_nx = '0;
            else if (loss_ev)      loss_cnt_nx = clr_cnt ? CNT_W'(1)
                                               : (loss_cnt == CNT_SAT) ? loss_cnt
                                               : loss_cnt + 1'b1;
            else if (clr_cnt)      loss_cnt_nx = '0;
            else                   loss_cnt_nx = loss_cnt;
        end

        assign in_run[i]                          = (state == ST_RUN);
        assign pll_rst[i]                         = pll_rst_q;
        assign domain_rst_n[i]                    = dom_rst_n_q;
        assign fault[i]                           = fault_q;
        assign lock_loss_cnt[i*CNT_W +: CNT_W]    = loss_cnt;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)        all_locked <= 1'b0;
        else if (!rst_rel) all_locked <= 1'b0;
        else               all_locked <= &in_run;
    end

endmodule
